// File: rtl/uart_tx_fifo_if.sv
// Bundle between the system, the TX FIFO/launcher and the UART transmitter.
// The slave modport is the FIFO side; the master modport drives writes and the done tick.
interface uart_tx_fifo_if #(
  parameter int unsigned DBits    = 8,
  parameter int unsigned AddrBits = 4
);
  logic                wr_en;
  logic [DBits-1:0]    wr_data;
  logic                tx_done_tick;
  logic                tx_start;
  logic [DBits-1:0]    tx_data;
  logic                tx_busy;
  logic                full;
  logic                empty;
  logic [AddrBits:0]   count;
  logic                overflow;

  modport master (
    output wr_en, wr_data, tx_done_tick,
    input  tx_start, tx_data, tx_busy, full, empty, count, overflow
  );

  modport slave (
    input  wr_en, wr_data, tx_done_tick,
    output tx_start, tx_data, tx_busy, full, empty, count, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular FIFO in front of a UART transmitter; launches one byte per start pulse
// and waits for the transmitter's done tick before launching the next.
module uart_tx_fifo #(
  parameter int unsigned DBits    = 8,
  parameter int unsigned AddrBits = 4
) (
  input logic           clk,
  input logic           areset,
  uart_tx_fifo_if.slave bus
);
  localparam int unsigned Depth = 2 ** AddrBits;
  localparam logic [AddrBits:0] FullCount = {1'b1, {AddrBits{1'b0}}};

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLaunch = 2'd1;
  localparam logic [1:0] StWait   = 2'd2;

  logic [DBits-1:0]    mem [Depth];
  logic [AddrBits-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrBits:0]   count_q, count_d;
  logic [1:0]          state_q, state_d;
  logic                overflow_q;
  logic                full, empty, push, pop;

  assign full  = (count_q == FullCount);
  assign empty = (count_q == '0);
  assign push  = bus.wr_en & ~full;
  assign pop   = (state_q == StLaunch);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = StIdle;
    case (state_q)
      StIdle:   state_d = empty ? StIdle : StLaunch;
      StLaunch: state_d = StWait;
      StWait:   state_d = bus.tx_done_tick ? StIdle : StWait;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= StIdle;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      state_q    <= state_d;
      // A pop in the same cycle does not rescue a write into a full FIFO.
      overflow_q <= bus.wr_en & full;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.tx_start = (state_q == StLaunch);
  assign bus.tx_busy  = (state_q == StLaunch) | (state_q == StWait);
  assign bus.tx_data  = mem[rd_ptr_q];
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected launch bytes, a monitor
// pops and compares on every tx_start; a small transmitter model returns done ticks.
module tb_uart_tx_fifo;
  logic clk;
  logic areset;
  logic model_done, man_done;
  bit   auto_done;
  int   done_delay;
  int   wait_cnt;
  int   cyc;
  int   last_done_cyc;
  bit   gap_valid, chk_gap, prev_start;
  int   checks, failures;
  logic [7:0] exp_q[$];

  uart_tx_fifo_if #(.DBits(8), .AddrBits(4)) bus ();

  uart_tx_fifo #(.DBits(8), .AddrBits(4)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  assign bus.tx_done_tick = model_done | man_done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Transmitter model: done tick after done_delay cycles of busy, only when auto_done.
  initial begin
    model_done = 1'b0;
    wait_cnt   = 0;
    forever begin
      @(negedge clk);
      model_done = 1'b0;
      if (auto_done && areset && bus.tx_busy && !bus.tx_start) begin
        wait_cnt++;
        if (wait_cnt >= done_delay) begin
          model_done    = 1'b1;
          wait_cnt      = 0;
          last_done_cyc = cyc;
          gap_valid     = 1'b1;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: every launch pulse must carry the next expected byte.
  initial begin
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) begin
        check("start_pulse_width", {31'd0, prev_start}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_start actual=%0h required=none", bus.tx_data);
        end else begin
          check("tx_data_order", {24'd0, bus.tx_data}, {24'd0, exp_q.pop_front()});
        end
        if (chk_gap && gap_valid) check("done_to_start_gap", cyc - last_done_cyc, 32'd2);
        gap_valid = 1'b0;
      end
      prev_start = (bus.tx_start === 1'b1);
    end
  end

  task automatic push_word(input logic [7:0] d, input bit accept);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    if (accept) exp_q.push_back(d);
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (!(bus.empty && !bus.tx_busy) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("drain_idle", {31'd0, bus.empty && !bus.tx_busy}, 32'd1);
    check("scoreboard_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; last_done_cyc = 0;
    gap_valid = 1'b0; chk_gap = 1'b0; auto_done = 1'b0; done_delay = 3;
    man_done = 1'b0; bus.wr_en = 1'b0; bus.wr_data = 8'h00;
    areset = 1'b1;
    #2 areset = 1'b0;
    #1;
    check("rst_empty", {31'd0, bus.empty}, 32'd1);
    check("rst_count", {27'd0, bus.count}, 32'd0);
    check("rst_full", {31'd0, bus.full}, 32'd0);
    check("rst_tx_start", {31'd0, bus.tx_start}, 32'd0);
    check("rst_tx_busy", {31'd0, bus.tx_busy}, 32'd0);
    check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
    @(negedge clk);
    areset = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte: launch one cycle after the write edge.
    auto_done = 1'b1;
    done_delay = 3;
    push_word(8'hA5, 1'b1);
    check("single_pre_start", {31'd0, bus.tx_start}, 32'd0);
    check("single_not_empty", {31'd0, bus.empty}, 32'd0);
    check("single_count1", {27'd0, bus.count}, 32'd1);
    @(negedge clk);
    check("single_start", {31'd0, bus.tx_start}, 32'd1);
    check("single_data", {24'd0, bus.tx_data}, 32'hA5);
    @(negedge clk);
    check("single_start_drop", {31'd0, bus.tx_start}, 32'd0);
    check("single_busy", {31'd0, bus.tx_busy}, 32'd1);
    check("single_count0", {27'd0, bus.count}, 32'd0);
    wait_idle(200);

    // Ordering with a 10-cycle transmitter and the done-to-start gap.
    done_delay = 10;
    gap_valid = 1'b0;
    chk_gap = 1'b1;
    for (int i = 1; i <= 5; i++) push_word(8'(i), 1'b1);
    wait_idle(500);
    chk_gap = 1'b0;

    // Full and overflow with the transmitter stalled.
    auto_done = 1'b0;
    for (int i = 0; i <= 16; i++) push_word(8'(i), 1'b1);
    check("full_count16", {27'd0, bus.count}, 32'd16);
    check("full_flag", {31'd0, bus.full}, 32'd1);
    check("full_no_overflow", {31'd0, bus.overflow}, 32'd0);
    push_word(8'h11, 1'b0);
    check("overflow_pulse", {31'd0, bus.overflow}, 32'd1);
    check("overflow_count", {27'd0, bus.count}, 32'd16);
    @(negedge clk);
    check("overflow_one_cycle", {31'd0, bus.overflow}, 32'd0);
    check("overflow_count_hold", {27'd0, bus.count}, 32'd16);
    auto_done = 1'b1;
    done_delay = 2;
    wait_idle(1000);

    // Wrap-around: 40 words through a 16-deep FIFO.
    done_delay = 1;
    for (int i = 0; i < 40; i++) begin
      int n;
      n = 0;
      while (bus.full && n < 200) begin
        @(negedge clk);
        n++;
      end
      push_word(8'(i + 128), 1'b1);
    end
    wait_idle(2000);
    check("wrap_empty", {31'd0, bus.empty}, 32'd1);

    // Concurrent push and pop with count = 3.
    auto_done = 1'b0;
    push_word(8'h40, 1'b1);
    repeat (2) @(negedge clk);
    check("conc_busy", {31'd0, bus.tx_busy}, 32'd1);
    for (int i = 1; i <= 3; i++) push_word(8'(8'h40 + i), 1'b1);
    check("conc_count3", {27'd0, bus.count}, 32'd3);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    check("conc_idle", {31'd0, bus.tx_busy}, 32'd0);
    @(negedge clk);
    check("conc_launch", {31'd0, bus.tx_start}, 32'd1);
    check("conc_launch_count", {27'd0, bus.count}, 32'd3);
    push_word(8'h44, 1'b1);
    check("conc_count_same", {27'd0, bus.count}, 32'd3);
    auto_done = 1'b1;
    done_delay = 2;
    wait_idle(500);

    // Reset mid-transfer with data pending.
    auto_done = 1'b0;
    push_word(8'h50, 1'b1);
    push_word(8'h51, 1'b1);
    push_word(8'h52, 1'b1);
    @(negedge clk);
    #2 areset = 1'b0;
    #1;
    check("midrst_empty", {31'd0, bus.empty}, 32'd1);
    check("midrst_count", {27'd0, bus.count}, 32'd0);
    check("midrst_tx_start", {31'd0, bus.tx_start}, 32'd0);
    check("midrst_tx_busy", {31'd0, bus.tx_busy}, 32'd0);
    check("midrst_overflow", {31'd0, bus.overflow}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    areset = 1'b1;
    repeat (5) @(negedge clk);
    check("postrst_empty", {31'd0, bus.empty}, 32'd1);
    check("postrst_busy", {31'd0, bus.tx_busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
